// File: rtl/matmul_seq_controller.sv
// -----------------------------------------------------------------------------
// matmul_seq_controller
//
// Sequencer for an N x N matrix-multiply datapath.
// A run has these phases:
//   1. Load A and then B from a shared source memory into two local buffers.
//   2. Step the accumulator through N^3 multiply-accumulate cycles.
//   3. Write each finished element to the result buffer.
//   4. Stream the N^2 results out under a valid/ready handshake.
// In mode 1 the B operand is read transposed (C = A * B^T).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      run request, sampled only while idle
//   mode       0: C = A*B, 1: C = A*B^T (latched with start)
//   mem_addr   source-memory read address (data valid in the same cycle)
//   m1_write   A buffer write strobe
//   m2_write   B buffer write strobe
//   m_idx      A/B buffer write index
//   a_idx      A buffer read index
//   b_idx      B buffer read index
//   res_rst    synchronous accumulator clear
//   res_ld     accumulate enable
//   fm_write   result buffer write strobe
//   fm_idx     result buffer write index
//   out_valid  streamed element valid
//   out_ready  downstream accepts the element
//   out_idx    result buffer read index of the streamed element
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//
// All outputs are decoded purely from registered state and counters.
// -----------------------------------------------------------------------------
module matmul_seq_controller #(
    parameter int N  = 3,
    parameter int AW = $clog2(2*N*N),
    parameter int IW = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    output logic [AW-1:0] mem_addr,
    output logic          m1_write,
    output logic          m2_write,
    output logic [IW-1:0] m_idx,
    output logic [IW-1:0] a_idx,
    output logic [IW-1:0] b_idx,
    output logic          res_rst,
    output logic          res_ld,
    output logic          fm_write,
    output logic [IW-1:0] fm_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_A,
        S_LOAD_B,
        S_MAC,
        S_STORE,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [IW-1:0] NN_LAST = IW'(N*N - 1);
    localparam logic [IW-1:0] N_LAST  = IW'(N - 1);
    localparam logic [IW-1:0] N_IW    = IW'(N);
    localparam logic [AW-1:0] B_BASE  = AW'(N*N);

    state_t        state_q;
    logic [IW-1:0] k_q;
    logic [IW-1:0] r_q;
    logic [IW-1:0] c_q;
    logic [IW-1:0] i_q;
    logic          mode_q;

    // State and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        k_q     <= '0;
                        r_q     <= '0;
                        c_q     <= '0;
                        i_q     <= '0;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    if (k_q == NN_LAST) begin
                        k_q     <= '0;
                        state_q <= S_LOAD_B;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_LOAD_B: begin
                    if (k_q == NN_LAST) begin
                        k_q     <= '0;
                        state_q <= S_MAC;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_MAC: begin
                    if (i_q == N_LAST) begin
                        i_q     <= '0;
                        state_q <= S_STORE;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                S_STORE: begin
                    // Walk the result matrix row-major: column first, then row.
                    if (c_q != N_LAST) begin
                        c_q     <= c_q + 1'b1;
                        state_q <= S_MAC;
                    end else if (r_q != N_LAST) begin
                        r_q     <= r_q + 1'b1;
                        c_q     <= '0;
                        state_q <= S_MAC;
                    end else begin
                        k_q     <= '0;
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    // The stream index only moves on an accepted transfer.
                    if (out_ready) begin
                        if (k_q == NN_LAST) begin
                            k_q     <= '0;
                            state_q <= S_DONE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        mem_addr  = '0;
        m1_write  = 1'b0;
        m2_write  = 1'b0;
        m_idx     = '0;
        a_idx     = '0;
        b_idx     = '0;
        res_rst   = 1'b0;
        res_ld    = 1'b0;
        fm_write  = 1'b0;
        fm_idx    = '0;
        out_valid = 1'b0;
        out_idx   = '0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        case (state_q)
            S_CLEAR: begin
                res_rst = 1'b1;
            end
            S_LOAD_A: begin
                mem_addr = AW'(k_q);
                m_idx    = k_q;
                m1_write = 1'b1;
            end
            S_LOAD_B: begin
                mem_addr = B_BASE + AW'(k_q);
                m_idx    = k_q;
                m2_write = 1'b1;
            end
            S_MAC: begin
                res_ld = 1'b1;
                a_idx  = r_q * N_IW + i_q;
                b_idx  = mode_q ? (c_q * N_IW + i_q) : (i_q * N_IW + c_q);
            end
            S_STORE: begin
                // Result buffer samples the pre-edge accumulator while it clears.
                fm_write = 1'b1;
                fm_idx   = r_q * N_IW + c_q;
                res_rst  = 1'b1;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_idx   = k_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_seq_controller.sv
`timescale 1ns/1ps
module tb_matmul_seq_controller;

    localparam int AW3 = 5;
    localparam int IW3 = 4;
    localparam int AW2 = 3;
    localparam int IW2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic out_ready = 1'b0;
    logic start3 = 1'b0, mode3 = 1'b0, start2 = 1'b0, mode2 = 1'b0;

    logic [AW3-1:0] mem_addr3;
    logic           m1_write3, m2_write3, res_rst3, res_ld3, fm_write3, out_valid3, busy3, done3;
    logic [IW3-1:0] m_idx3, a_idx3, b_idx3, fm_idx3, out_idx3;
    logic [AW2-1:0] mem_addr2;
    logic           m1_write2, m2_write2, res_rst2, res_ld2, fm_write2, out_valid2, busy2, done2;
    logic [IW2-1:0] m_idx2, a_idx2, b_idx2, fm_idx2, out_idx2;

    always #5 clk = ~clk;

    matmul_seq_controller #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3),
        .mem_addr(mem_addr3), .m1_write(m1_write3), .m2_write(m2_write3),
        .m_idx(m_idx3), .a_idx(a_idx3), .b_idx(b_idx3),
        .res_rst(res_rst3), .res_ld(res_ld3), .fm_write(fm_write3), .fm_idx(fm_idx3),
        .out_valid(out_valid3), .out_ready(out_ready), .out_idx(out_idx3),
        .busy(busy3), .done(done3)
    );

    matmul_seq_controller #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2),
        .mem_addr(mem_addr2), .m1_write(m1_write2), .m2_write(m2_write2),
        .m_idx(m_idx2), .a_idx(a_idx2), .b_idx(b_idx2),
        .res_rst(res_rst2), .res_ld(res_ld2), .fm_write(fm_write2), .fm_idx(fm_idx2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_idx(out_idx2),
        .busy(busy2), .done(done2)
    );

    wire [7:0]  strb3 = {m1_write3, m2_write3, res_rst3, res_ld3, fm_write3, out_valid3, busy3, done3};
    wire [24:0] idx3  = {mem_addr3, m_idx3, a_idx3, b_idx3, fm_idx3, out_idx3};
    wire [7:0]  strb2 = {m1_write2, m2_write2, res_rst2, res_ld2, fm_write2, out_valid2, busy2, done2};
    wire [12:0] idx2  = {mem_addr2, m_idx2, a_idx2, b_idx2, fm_idx2, out_idx2};

    // Datapath models: source memory, A/B buffers, accumulator, result buffer.
    int mem3[18];
    int abuf3[9], bbuf3[9], fbuf3[9];
    int acc3 = 0;
    int mem2[8];
    int abuf2[4], bbuf2[4], fbuf2[4];
    int acc2 = 0;

    always @(posedge clk) begin
        if (m1_write3) abuf3[m_idx3] <= mem3[mem_addr3];
        if (m2_write3) bbuf3[m_idx3] <= mem3[mem_addr3];
        if (res_rst3) acc3 <= 0;
        else if (res_ld3) acc3 <= acc3 + abuf3[a_idx3] * bbuf3[b_idx3];
        if (fm_write3) fbuf3[fm_idx3] <= acc3;
        if (m1_write2) abuf2[m_idx2] <= mem2[mem_addr2];
        if (m2_write2) bbuf2[m_idx2] <= mem2[mem_addr2];
        if (res_rst2) acc2 <= 0;
        else if (res_ld2) acc2 <= acc2 + abuf2[a_idx2] * bbuf2[b_idx2];
        if (fm_write2) fbuf2[fm_idx2] <= acc2;
    end

    // Event logs sampled mid-cycle.
    int ld_addr3[$], ld_kind3[$], ld_idx3[$], fm_log3[$], bq3[$], out_q3[$], oidx_q3[$], out_q2[$];
    int done_cnt3 = 0;

    always @(negedge clk) begin
        if (m1_write3 || m2_write3) begin
            ld_addr3.push_back(int'(mem_addr3));
            ld_kind3.push_back(int'({m2_write3, m1_write3}));
            ld_idx3.push_back(int'(m_idx3));
        end
        if (fm_write3) fm_log3.push_back(int'(fm_idx3));
        if (res_ld3) bq3.push_back(int'(b_idx3));
        if (out_valid3 && out_ready) begin
            out_q3.push_back(fbuf3[out_idx3]);
            oidx_q3.push_back(int'(out_idx3));
        end
        if (done3) done_cnt3 <= done_cnt3 + 1;
        if (out_valid2 && out_ready) out_q2.push_back(fbuf2[out_idx2]);
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp3[9];

    task automatic chk(input string tag, input int got, input int expv);
        n_cmp++;
        assert (got === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic clr3();
        ld_addr3.delete(); ld_kind3.delete(); ld_idx3.delete();
        fm_log3.delete(); bq3.delete(); out_q3.delete(); oidx_q3.delete();
    endtask

    // Start is sampled at the edge this task ends on; mode is then flipped
    // to show it was latched.
    task automatic go3(input logic m);
        @(posedge clk); #1; start3 = 1'b1; mode3 = m;
        @(posedge clk); #1; start3 = 1'b0; mode3 = ~m;
    endtask

    task automatic go2(input logic m);
        @(posedge clk); #1; start2 = 1'b1; mode2 = m;
        @(posedge clk); #1; start2 = 1'b0; mode2 = ~m;
    endtask

    // Counts edges until done is seen; optionally stalls 5 cycles at stall_at.
    task automatic wait_done3(output int n, input int stall_at);
        bit stalled = 1'b0;
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1; n++;
            if (done3) break;
            if (stall_at >= 0 && !stalled && out_valid3 && int'(out_idx3) == stall_at) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1; n++;
                    chk("stall_out_idx", int'(out_idx3), stall_at);
                    chk("stall_out_valid", int'(out_valid3), 1);
                end
                out_ready = 1'b1;
            end
        end
    endtask

    task automatic wait_done2(output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1; n++;
            if (done2) break;
        end
    endtask

    task automatic chk_out3(input string tag);
        chk({tag, "_count"}, out_q3.size(), 9);
        for (int j = 0; j < 9 && j < out_q3.size(); j++) chk(tag, out_q3[j], exp3[j]);
    endtask

    task automatic load_ident();
        for (int j = 0; j < 9; j++) begin
            mem3[j]     = j + 1;
            mem3[9 + j] = (j % 4 == 0) ? 1 : 0;
            exp3[j]     = j + 1;
        end
    endtask

    initial begin
        int n, nn, d0;
        int exp_t2[9] = '{14, 32, 50, 32, 77, 122, 50, 122, 194};
        int exp_n2[4] = '{19, 22, 43, 50};

        // Reset state.
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes_n3", int'(strb3), 0);
        chk("rst_indices_n3", int'(idx3), 0);
        chk("rst_strobes_n2", int'(strb2), 0);
        chk("rst_indices_n2", int'(idx2), 0);
        rst = 1'b1;

        // N=3, mode 0, A=1..9, B=I.
        load_ident();
        clr3();
        go3(1'b0);
        wait_done3(n, -1);
        chk("t1_done_edge", n, 64);
        @(posedge clk); #1;
        chk("t1_done_one_cycle", int'(done3), 0);
        chk("t1_idle_after", int'(busy3), 0);
        chk("t1_load_count", ld_addr3.size(), 18);
        for (int j = 0; j < 18 && j < ld_addr3.size(); j++) begin
            chk("t1_mem_addr", ld_addr3[j], j);
            chk("t1_write_sel", ld_kind3[j], (j < 9) ? 1 : 2);
            chk("t1_m_idx", ld_idx3[j], j % 9);
        end
        chk("t1_fm_count", fm_log3.size(), 9);
        for (int j = 0; j < 9 && j < fm_log3.size(); j++) chk("t1_fm_idx", fm_log3[j], j);
        for (int j = 0; j < 9 && j < oidx_q3.size(); j++) chk("t1_out_idx", oidx_q3[j], j);
        chk("t1_mac_count", bq3.size(), 27);
        for (int j = 0; j < 3 && j < bq3.size(); j++) chk("t1_b_idx_first", bq3[j], 3 * j);
        chk_out3("t1_result");
        chk("t1_done_pulses", done_cnt3, 1);

        // N=3, mode 1, A=B=1..9.
        for (int j = 0; j < 9; j++) begin
            mem3[9 + j] = j + 1;
            exp3[j]     = exp_t2[j];
        end
        clr3();
        go3(1'b1);
        wait_done3(n, -1);
        chk("t2_done_edge", n, 64);
        for (int j = 0; j < 3 && j < bq3.size(); j++) chk("t2_b_idx_first", bq3[j], j);
        chk_out3("t2_result");

        // N=2, mode 0.
        for (int j = 0; j < 8; j++) mem2[j] = j + 1;
        out_q2.delete();
        go2(1'b0);
        wait_done2(n);
        chk("t3_done_edge", n, 25);
        chk("t3_count", out_q2.size(), 4);
        for (int j = 0; j < 4 && j < out_q2.size(); j++) chk("t3_result", out_q2[j], exp_n2[j]);

        // Backpressure: 5-cycle stall at out_idx 4.
        load_ident();
        clr3();
        go3(1'b0);
        wait_done3(n, 4);
        chk("t4_done_edge", n, 69);
        chk_out3("t4_result");

        // Abort during MAC at r=1.
        clr3();
        go3(1'b0);
        n = 0;
        while (!(res_ld3 && a_idx3 >= 4'd3) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("t5_reached_row1", int'(res_ld3 && a_idx3 >= 4'd3), 1);
        d0 = done_cnt3;
        #2 rst = 1'b0;
        #1;
        chk("t5_abort_strobes", int'(strb3), 0);
        chk("t5_abort_indices", int'(idx3), 0);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt3, d0);
        chk("t5_busy_after", int'(busy3), 0);
        clr3();
        go3(1'b0);
        wait_done3(n, -1);
        chk("t5_rerun_done_edge", n, 64);
        chk_out3("t5_rerun_result");

        // Start pulse during LOAD_B is ignored.
        clr3();
        d0 = done_cnt3;
        go3(1'b0);
        nn = 0;
        while (!m2_write3 && nn < 100) begin
            @(posedge clk); #1; nn++;
        end
        start3 = 1'b1;
        @(posedge clk); #1; nn++;
        start3 = 1'b0;
        wait_done3(n, -1);
        chk("t6_done_edge", n + nn, 64);
        chk_out3("t6_result");

        // Start held through DONE: one IDLE cycle, then CLEAR.
        start3 = 1'b1;
        @(posedge clk); #1;
        chk("t6_idle_busy", int'(busy3), 0);
        chk("t6_idle_res_rst", int'(res_rst3), 0);
        @(posedge clk); #1;
        chk("t6_clear_res_rst", int'(res_rst3), 1);
        chk("t6_clear_busy", int'(busy3), 1);
        start3 = 1'b0;
        clr3();
        wait_done3(n, -1);
        chk("t6_restart_done_edge", n, 64);
        chk_out3("t6_restart_result");
        chk("t6_done_pulses", done_cnt3 - d0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
